// File: rtl/cbus_mem_responder_pkg.sv
// Shared cbus types and defaults for the memory responder.
// Holds request/response payloads, burst encodings and the responder state enum.
package cbus_mem_responder_pkg;

  localparam int unsigned AXI_BURST_LEN = 16;
  localparam int unsigned CBUS_ADDR_W   = 64;
  localparam int unsigned CBUS_DATA_W   = 64;
  localparam int unsigned CBUS_STRB_W   = CBUS_DATA_W / 8;
  localparam int unsigned CBUS_MEM_BITS = 16;
  localparam int unsigned CBUS_LATENCY  = 2;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,  MLEN2  = 4'd1,  MLEN3  = 4'd2,  MLEN4  = 4'd3,
    MLEN5  = 4'd4,  MLEN6  = 4'd5,  MLEN7  = 4'd6,  MLEN8  = 4'd7,
    MLEN9  = 4'd8,  MLEN10 = 4'd9,  MLEN11 = 4'd10, MLEN12 = 4'd11,
    MLEN13 = 4'd12, MLEN14 = 4'd13, MLEN15 = 4'd14, MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_type_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    msize_t                 size;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_DATA_W-1:0] data;
    mlen_t                  len;
    axi_burst_type_t        burst;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2,
    TURN = 2'd3
  } cbus_rsp_state_t;

  // True when addr falls inside [base, base + 2^mem_bits).
  function automatic logic addr_in_window(input logic [CBUS_ADDR_W-1:0] addr,
                                          input logic [CBUS_ADDR_W-1:0] base,
                                          input int unsigned            mem_bits);
    logic [CBUS_ADDR_W-1:0] span;
    span = CBUS_ADDR_W'(1) << mem_bits;
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/cbus_mem_responder_ram.sv
// Single-port word RAM with byte strobes and one cycle of read latency.
// Contents are never reset; reads and writes are exclusive per cycle.
module cbus_mem_responder_ram #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 64
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W/8-1:0]   strb_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (strb_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cbus_mem_responder.sv
// cbus target backed by a word RAM: FIXED/INCR bursts, strobed writes,
// programmable first-beat latency, out-of-window accesses complete harmlessly.
module cbus_mem_responder
  import cbus_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_BITS  = CBUS_MEM_BITS,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned LATENCY   = CBUS_LATENCY
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int unsigned WORD_W  = MEM_BITS - 3;
  localparam int unsigned IDX_W   = $clog2(AXI_BURST_LEN);
  localparam int unsigned BEATS_W = IDX_W + 1;
  localparam int unsigned WAIT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  cbus_rsp_state_t         state_q, state_d;
  logic                    is_write_q, is_write_d;
  logic                    fixed_q, fixed_d;
  logic                    in_win_q, in_win_d;
  logic [WORD_W-1:0]       base_q, base_d;
  logic [BEATS_W-1:0]      beats_q, beats_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    ready_q, ready_d;
  logic                    last_q, last_d;
  logic [WORD_W-1:0]       cur_word, nxt_word, ram_addr;
  logic                    ram_en, ram_we;
  logic [CBUS_DATA_W-1:0]  ram_rdata, rd_data;
  logic                    unused_size;

  assign unused_size = ^creq.size;

  // FIXED bursts pin the word; INCR walks it and wraps modulo the memory size.
  assign cur_word = fixed_q ? base_q : base_q + WORD_W'(idx_q);
  assign nxt_word = fixed_q ? base_q : base_q + WORD_W'(idx_q) + WORD_W'(1);

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    fixed_d    = fixed_q;
    in_win_d   = in_win_q;
    base_d     = base_q;
    beats_d    = beats_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = cur_word;

    unique case (state_q)
      IDLE: begin
        if (creq.valid) begin
          is_write_d = creq.is_write;
          fixed_d    = (creq.burst == AXI_BURST_FIXED);
          in_win_d   = addr_in_window(creq.addr, BASE_ADDR, MEM_BITS);
          base_d     = creq.addr[MEM_BITS-1:3];
          beats_d    = BEATS_W'(creq.len) + BEATS_W'(1);
          idx_d      = '0;
          wait_d     = WAIT_W'(LATENCY - 1);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          ram_en  = !is_write_q;
          state_d = BEAT;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      BEAT: begin
        if (!creq.valid) begin
          state_d = IDLE;
        end else begin
          ram_we = is_write_q && in_win_q;
          ram_en = ram_we;
          if (beats_q == BEATS_W'(1)) begin
            state_d = TURN;
          end else begin
            beats_d = beats_q - BEATS_W'(1);
            idx_d   = idx_q + IDX_W'(1);
            // Prefetch the next read word so it lands with the next ready.
            if (!is_write_q) begin
              ram_en   = 1'b1;
              ram_addr = nxt_word;
            end
          end
        end
      end
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == BEAT);
    last_d  = (state_d == BEAT) && (beats_d == BEATS_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      fixed_q    <= 1'b0;
      in_win_q   <= 1'b0;
      base_q     <= '0;
      beats_q    <= '0;
      idx_q      <= '0;
      wait_q     <= '0;
      ready_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      fixed_q    <= fixed_d;
      in_win_q   <= in_win_d;
      base_q     <= base_d;
      beats_q    <= beats_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      ready_q    <= ready_d;
      last_q     <= last_d;
    end
  end

  cbus_mem_responder_ram #(
    .ADDR_W (WORD_W),
    .DATA_W (CBUS_DATA_W)
  ) u_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .strb_i  (creq.strobe),
    .wdata_i (creq.data),
    .rdata_o (ram_rdata)
  );

  // Out-of-window reads and all write beats return zero data.
  assign rd_data = (ready_q && !is_write_q && in_win_q) ? ram_rdata : '0;
  assign cresp   = '{ready: ready_q, last: last_q, data: rd_data};

endmodule
